// File: rtl/sm2_pkg.sv
// Shared SM2 constants: field width, curve prime, converter FSM states and op codes.
package sm2_pkg;

    localparam int WIDTH = 256;

    localparam logic [WIDTH-1:0] SM2_P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_INV_GO   = 6'b000010,
        S_INV_WAIT = 6'b000100,
        S_MUL_GO   = 6'b001000,
        S_MUL_WAIT = 6'b010000,
        S_DONE     = 6'b100000
    } state_t;

    localparam logic [1:0] OP_ZI2 = 2'd0;
    localparam logic [1:0] OP_ZI3 = 2'd1;
    localparam logic [1:0] OP_X   = 2'd2;
    localparam logic [1:0] OP_Y   = 2'd3;

endpackage

// File: rtl/jac_to_affine_ctrl.sv
// Sequencer for the Jacobian-to-affine conversion: one inversion, then four chained multiplies.
module jac_to_affine_ctrl
    import sm2_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       z_zero,
    input  logic       inv_finish,
    input  logic       mul_finish,
    output logic       cap,
    output logic       zi_we,
    output logic       mul_we,
    output logic       inv_start,
    output logic       mul_start,
    output logic [1:0] op,
    output logic       busy,
    output logic       done,
    output logic       inf
);
    state_t state;

    assign cap    = (state == S_IDLE) && start;
    assign zi_we  = (state == S_INV_WAIT) && inv_finish;
    assign mul_we = (state == S_MUL_WAIT) && mul_finish;

    // Start pulses and done are registered on the transition into their state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op        <= OP_ZI2;
            inv_start <= 1'b0;
            mul_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            inf       <= 1'b0;
        end else begin
            inv_start <= 1'b0;
            mul_start <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        inf  <= 1'b0;
                        if (z_zero) begin
                            inf   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            inv_start <= 1'b1;
                            state     <= S_INV_GO;
                        end
                    end
                end
                S_INV_GO: state <= S_INV_WAIT;
                S_INV_WAIT: begin
                    if (inv_finish) begin
                        op        <= OP_ZI2;
                        mul_start <= 1'b1;
                        state     <= S_MUL_GO;
                    end
                end
                S_MUL_GO: state <= S_MUL_WAIT;
                S_MUL_WAIT: begin
                    if (mul_finish) begin
                        if (op == OP_Y) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            op        <= op + 2'd1;
                            mul_start <= 1'b1;
                            state     <= S_MUL_GO;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mod_inv.sv
// Binary extended-Euclid modular inverse; never terminates for in == 0, so callers must filter it.
module mod_inv #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_signal,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] inv_res,
    output logic             finish
);
    logic             busy;
    logic [WIDTH-1:0] u, v, x1, x2;

    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        s = {1'b0, x} + (x[0] ? {1'b0, m} : '0);
        return WIDTH'(s >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] m);
        return (x >= y) ? (x - y) : (x - y + m);
    endfunction

    // A new start is refused during the finish cycle, so idle is reached one cycle after finish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            u       <= '0;
            v       <= '0;
            x1      <= '0;
            x2      <= '0;
            inv_res <= '0;
            finish  <= 1'b0;
        end else begin
            finish <= 1'b0;
            if (busy) begin
                if (u == WIDTH'(1) || v == WIDTH'(1)) begin
                    busy    <= 1'b0;
                    finish  <= 1'b1;
                    inv_res <= (u == WIDTH'(1)) ? x1 : x2;
                end else if (!u[0]) begin
                    u  <= u >> 1;
                    x1 <= half_mod(x1, p);
                end else if (!v[0]) begin
                    v  <= v >> 1;
                    x2 <= half_mod(x2, p);
                end else if (u >= v) begin
                    u  <= u - v;
                    x1 <= sub_mod(x1, x2, p);
                end else begin
                    v  <= v - u;
                    x2 <= sub_mod(x2, x1, p);
                end
            end else if (start_signal && !finish) begin
                busy <= 1'b1;
                u    <= in;
                v    <= p;
                x1   <= WIDTH'(1);
                x2   <= '0;
            end
        end
    end

endmodule

// File: rtl/mod_mul.sv
// Bit-serial modular multiplier: res = a*b mod p, MSB-first double-and-add, one bit per cycle.
module mod_mul #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] res,
    output logic             finish
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] dbl_red;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   sum;

    // b and p are read live; the caller holds them stable while busy
    always_comb begin
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= {1'b0, p}) ? WIDTH'(dbl - {1'b0, p}) : dbl[WIDTH-1:0];
        sum     = {1'b0, dbl_red} + (a_r[WIDTH-1] ? {1'b0, b} : '0);
        acc_nxt = (sum >= {1'b0, p}) ? WIDTH'(sum - {1'b0, p}) : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            a_r    <= '0;
            acc    <= '0;
            res    <= '0;
            finish <= 1'b0;
        end else begin
            finish <= 1'b0;
            if (busy) begin
                acc <= acc_nxt;
                a_r <= a_r << 1;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy   <= 1'b0;
                    finish <= 1'b1;
                    res    <= acc_nxt;
                end
            end else if (start) begin
                busy <= 1'b1;
                acc  <= '0;
                a_r  <= a;
                cnt  <= CW'(WIDTH);
            end
        end
    end

endmodule

// File: rtl/jac_to_affine.sv
// Jacobian (X, Y, Z) to affine (X/Z^2, Y/Z^3) mod p using one mod_inv and one shared mod_mul.
module jac_to_affine #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] X_in,
    input  logic [WIDTH-1:0] Y_in,
    input  logic [WIDTH-1:0] Z_in,
    output logic             busy,
    output logic             done,
    output logic             inf,
    output logic [WIDTH-1:0] x_aff,
    output logic [WIDTH-1:0] y_aff
);
    import sm2_pkg::*;

    logic             rst_n;
    logic             cap, zi_we, mul_we, inv_start, mul_start;
    logic             inv_finish, mul_finish;
    logic [1:0]       op;
    logic [WIDTH-1:0] p_r, x_r, y_r, z_r, zi_r, t2_r, t3_r;
    logic [WIDTH-1:0] inv_res, mul_res, mul_a, mul_b;

    assign rst_n = ~rst;

    jac_to_affine_ctrl u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .z_zero     (Z_in == '0),
        .inv_finish (inv_finish),
        .mul_finish (mul_finish),
        .cap        (cap),
        .zi_we      (zi_we),
        .mul_we     (mul_we),
        .inv_start  (inv_start),
        .mul_start  (mul_start),
        .op         (op),
        .busy       (busy),
        .done       (done),
        .inf        (inf)
    );

    mod_inv #(.WIDTH(WIDTH)) u_inv (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_signal (inv_start),
        .in           (z_r),
        .p            (p_r),
        .inv_res      (inv_res),
        .finish       (inv_finish)
    );

    // Operands come only from registers, so they stay put for the whole multiply
    always_comb begin
        mul_a = zi_r;
        mul_b = zi_r;
        unique case (op)
            OP_ZI2: begin mul_a = zi_r; mul_b = zi_r; end
            OP_ZI3: begin mul_a = t2_r; mul_b = zi_r; end
            OP_X:   begin mul_a = x_r;  mul_b = t2_r; end
            OP_Y:   begin mul_a = y_r;  mul_b = t3_r; end
            default: begin mul_a = zi_r; mul_b = zi_r; end
        endcase
    end

    mod_mul #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (mul_a),
        .b      (mul_b),
        .p      (p_r),
        .res    (mul_res),
        .finish (mul_finish)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_r   <= '0;
            x_r   <= '0;
            y_r   <= '0;
            z_r   <= '0;
            zi_r  <= '0;
            t2_r  <= '0;
            t3_r  <= '0;
            x_aff <= '0;
            y_aff <= '0;
        end else begin
            if (cap) begin
                p_r   <= p;
                x_r   <= X_in;
                y_r   <= Y_in;
                z_r   <= Z_in;
                x_aff <= '0;
                y_aff <= '0;
            end
            if (zi_we) zi_r <= inv_res;
            if (mul_we) begin
                unique case (op)
                    OP_ZI2:  t2_r  <= mul_res;
                    OP_ZI3:  t3_r  <= mul_res;
                    OP_X:    x_aff <= mul_res;
                    OP_Y:    y_aff <= mul_res;
                    default: t2_r  <= mul_res;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jac_to_affine.sv
// Scoreboard bench for jac_to_affine: expectations queued at start, checked on each done pulse.
module tb_jac_to_affine;
    import sm2_pkg::*;

    localparam logic [WIDTH-1:0] GX =
        256'h32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7;
    localparam logic [WIDTH-1:0] GY =
        256'hBC3736A2_F4F6779C_59BDCEE3_6B692153_D0A9877C_C62A4740_02DF32E5_2139F0A0;
    localparam int TIMEOUT = 20000;

    logic             clk = 1'b0;
    logic             rst, start;
    logic [WIDTH-1:0] p, X_in, Y_in, Z_in;
    logic             busy, done, inf;
    logic [WIDTH-1:0] x_aff, y_aff;

    typedef struct {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             inf;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    int   inv_starts = 0;

    always #5 clk = ~clk;

    jac_to_affine #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .p     (p),
        .X_in  (X_in),
        .Y_in  (Y_in),
        .Z_in  (Z_in),
        .busy  (busy),
        .done  (done),
        .inf   (inf),
        .x_aff (x_aff),
        .y_aff (y_aff)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) if (dut.inv_start) inv_starts++;

    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("x_aff", x_aff, e.x);
                check("y_aff", y_aff, e.y);
                check("inf", WIDTH'(inf), WIDTH'(e.inf));
            end
        end
    end

    task automatic drive(input logic [WIDTH-1:0] pp, xx, yy, zz);
        @(negedge clk);
        p = pp; X_in = xx; Y_in = yy; Z_in = zz;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int c0);
        int n = 0;
        while (done_cnt == c0 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == c0) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic wait_state(input string tag, input state_t s);
        int n = 0;
        while (dut.u_ctrl.state != s && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (dut.u_ctrl.state != s) check({tag, "_state_timeout"}, 0, 1);
    endtask

    task automatic run_job(input string tag, input logic [WIDTH-1:0] pp, xx, yy, zz,
                           input logic [WIDTH-1:0] ex, ey);
        int c0 = done_cnt;
        sb.push_back('{x: ex, y: ey, inf: 1'b0});
        drive(pp, xx, yy, zz);
        wait_done(tag, c0);
    endtask

    initial begin
        int c0;
        int s0;
        rst = 1'b1; start = 1'b0;
        p = '0; X_in = '0; Y_in = '0; Z_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", WIDTH'(busy), 0);
        check("rst_done", WIDTH'(done), 0);
        check("rst_inf", WIDTH'(inf), 0);
        check("rst_x", x_aff, 0);
        check("rst_y", y_aff, 0);

        run_job("small", 23, 5, 7, 3, 21, 19);
        run_job("sm2_z2", SM2_P, 4, 8, 2, 1, 1);
        run_job("ident", SM2_P, GX, GY, 1, GX, GY);

        // Point at infinity: done and inf one cycle after the start edge, no inversion
        c0 = done_cnt;
        s0 = inv_starts;
        sb.push_back('{x: '0, y: '0, inf: 1'b1});
        drive(23, 5, 7, 0);
        check("inf_done_k1", WIDTH'(done), 1);
        check("inf_flag_k1", WIDTH'(inf), 1);
        @(negedge clk);
        check("inf_done_count", WIDTH'(done_cnt - c0), 1);
        check("inf_no_inv", WIDTH'(inv_starts - s0), 0);
        check("inf_busy_clr", WIDTH'(busy), 0);

        // Second start during inversion must be ignored
        c0 = done_cnt;
        sb.push_back('{x: 21, y: 19, inf: 1'b0});
        drive(23, 5, 7, 3);
        wait_state("busy", S_INV_WAIT);
        drive(23, 1, 2, 5);
        wait_done("busy", c0);
        repeat (50) @(negedge clk);
        check("busy_one_done", WIDTH'(done_cnt - c0), 1);

        // Reset in the middle of a multiply
        c0 = done_cnt;
        sb.push_back('{x: 21, y: 19, inf: 1'b0});
        drive(23, 5, 7, 3);
        wait_state("midrst", S_MUL_WAIT);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", WIDTH'(busy), 0);
        check("midrst_done", WIDTH'(done), 0);
        check("midrst_inf", WIDTH'(inf), 0);
        check("midrst_x", x_aff, 0);
        check("midrst_y", y_aff, 0);
        check("midrst_state", WIDTH'(dut.u_ctrl.state), WIDTH'(S_IDLE));
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_no_done", WIDTH'(done_cnt - c0), 0);
        run_job("after_rst", 23, 5, 7, 3, 21, 19);

        repeat (5) @(negedge clk);
        check("sb_empty", WIDTH'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jac_to_affine.md
# jac_to_affine

Converts an SM2 point from Jacobian projective coordinates (X, Y, Z) to affine coordinates (x = X·Z⁻², y = Y·Z⁻³ mod p). It sits directly downstream of the scalar-multiplication core and is the consumer of `mod_inv`. It instantiates one `mod_inv` to obtain Z⁻¹ and one shared `mod_mul` for the four products. It delivers affine results to the signature/verification logic.

## Interface
- `WIDTH`, default 256: coordinate and modulus width.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: **asynchronous, active-high** reset.
  - Drives `rst_n = ~rst` into both sub-blocks.
- `start`, input, 1: request pulse.
  - Sampled only in IDLE; ignored otherwise.
- `p`, input, WIDTH: field modulus, odd, p > 2.
  - Captured on accepted `start`.
- `X_in`, `Y_in`, `Z_in`, input, WIDTH: Jacobian coordinates, each < p.
  - Captured on accepted `start`.
- `busy`, output, 1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done`, output, 1: one-cycle completion pulse.
- `inf`, output, 1: result is the point at infinity (Z_in == 0).
- `x_aff`, `y_aff`, output, WIDTH: affine result.
  - Held stable from `done` until the next accepted `start`.

## Operation
- **States:** IDLE, INV_GO, INV_WAIT, MUL_GO, MUL_WAIT, DONE.
- **IDLE**
  - On `start`: capture p, X, Y, Z into registers.
  - Clear `inf`, `x_aff`, `y_aff`.
  - If Z_in == 0: go to DONE with `inf` = 1 and x_aff = y_aff = 0; `mod_inv` is never started, because it does not terminate on input 0.
  - Otherwise go to INV_GO.
- **INV_GO**
  - Drive `mod_inv.start_signal` = 1 for exactly this cycle, with in = Z_r and p = p_r.
  - Go to INV_WAIT.
- **INV_WAIT**
  - Wait for `mod_inv.finish`.
  - `inv_res` is valid only in the finish cycle; capture it into zi_r in that cycle.
  - Clear op counter `op` (2 bits) and go to MUL_GO.
- **MUL_GO**
  - Pulse `mod_mul.start` for one cycle with operands selected by `op`:
    - op 0: zi·zi → t2_r
    - op 1: t2_r·zi → t3_r
    - op 2: X_r·t2_r → x_aff
    - op 3: Y_r·t3_r → y_aff
  - Go to MUL_WAIT.
- **MUL_WAIT**
  - On `mod_mul.finish`: write `res` to the destination register for the current `op`.
  - If op == 3, go to DONE; else increment `op` and go to MUL_GO.
- **DONE**
  - Assert `done` for one cycle; go to IDLE.
- **Operand stability:** `mod_mul` operands and p come from registers only and are held stable through MUL_WAIT.
- **Width rule:** all values are < p at every step. No intermediate wider than WIDTH is stored; the multiplier performs the full reduction.

## Timing
- **Reset values:** `busy` = 0, `done` = 0, `inf` = 0, `x_aff` = 0, `y_aff` = 0, state = IDLE. All internal registers are 0.
- **Reset mid-operation:** everything returns to the reset values immediately. Sub-blocks are also reset, and no `done` is emitted for the aborted job.
- **Z == 0 path:** `start` sampled at edge k → DONE at k+1, so `done` is high in cycle k+1.
- **Normal path latency:** 1 (INV_GO) + T_inv + 4·(1 + T_mul) + 1 cycles from the `start` edge to `done`.
  - T_inv and T_mul are the data-dependent sub-block latencies, measured from their start pulse to their finish pulse.
- **`start` while busy:** ignored. No capture, and the in-flight result is unaffected.
- **`start` in the cycle after `done`:** accepted (state is IDLE).
- **Sub-block recovery:** `mod_inv` returns to idle one cycle after its finish pulse. The block never restarts `mod_inv` sooner than that.

## Structure
- Shared package `sm2_pkg`:
  - `WIDTH` = 256.
  - SM2 prime constant `SM2_P`.
  - State-encoding localparams (one-hot, 6 bits).
  - Op codes `OP_ZI2`, `OP_ZI3`, `OP_X`, `OP_Y`.
- Sub-module `jac_to_affine_ctrl` holds the FSM and op counter, which keeps the datapath mux separate from control.
- Instances: one `mod_inv`, one `mod_mul`. `mod_mul` ports: clk, rst_n, start, a, b, p, res, finish; it returns a·b mod p.

## Test plan
- **Small modulus:** p = 23, X = 5, Y = 7, Z = 3 → zi = 8, x_aff = 21, y_aff = 19, inf = 0, one `done` pulse.
- **SM2 prime, Z = 2:** p = SM2_P, X = 4, Y = 8, Z = 2 → x_aff = 1, y_aff = 1.
- **Identity Z:** X = Gx, Y = Gy, Z = 1 with SM2_P → x_aff = Gx, y_aff = Gy.
- **Point at infinity:** Z = 0 → `done` and `inf` = 1 one cycle after the `start` edge, x_aff = y_aff = 0, `mod_inv` start never asserted.
- **Start while busy:** second `start` with different data during INV_WAIT → ignored; the result matches the first job and exactly one `done` is emitted.
- **Reset mid-operation:** assert `rst` during MUL_WAIT → all outputs 0 and state IDLE immediately. A subsequent p = 23 job still returns (21, 19).
